// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM/WB stage register and its helpers.
package mem_wb_pkg;

  // Default width of each writeback data half.
  localparam int unsigned DATA_W_DEF = 8;

  // Bottom-half source indices within bot_src / sel_bot.
  localparam int unsigned SRC_SFR = 0;
  localparam int unsigned SRC_EX  = 1;
  localparam int unsigned SRC_LD  = 2;

  // Width of the load-wait watchdog counter.
  localparam int unsigned CNT_W = 8;

  // Load-wait controller states.
  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_and_or_mux.sv
// AND-OR multiplexer over N flattened sources, with a one-hot select check.
module onehot_and_or_mux #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 3
) (
  input  logic [N-1:0]        sel,
  input  logic [N*DATA_W-1:0] src,
  output logic [DATA_W-1:0]   data_c,
  output logic                onehot_c
);

  logic seen;
  logic multi;

  // OR together every source whose select bit is set; no bits set gives zero.
  always_comb begin
    data_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      data_c = data_c | (src[i*DATA_W +: DATA_W] & {DATA_W{sel[i]}});
    end
  end

  // One-hot means at least one bit set and no second bit after it.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      multi = multi | (seen & sel[i]);
      seen  = seen | sel[i];
    end
    onehot_c = seen & ~multi;
  end

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB stage register: selects writeback top/bottom data, waits for loads,
// and registers the result with valid, stall, flush and a load watchdog.
module mem_wb_stage_reg
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned NUM_BOT_SRC = 3,
  parameter int unsigned LD_IDX      = SRC_LD,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic                          sel_top,
  input  logic [NUM_BOT_SRC-1:0]        sel_bot,
  input  logic [DATA_W-1:0]             ex_data_top,
  input  logic [DATA_W-1:0]             ld_res_top,
  input  logic [NUM_BOT_SRC*DATA_W-1:0] bot_src,
  input  logic                          ld_valid,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data_top,
  output logic [DATA_W-1:0]             out_data_bot,
  output logic                          stall_req,
  output logic                          sel_err,
  output logic                          ld_timeout
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               timeout_next;

  logic [DATA_W-1:0]  top_sel;
  logic [DATA_W-1:0]  bot_sel;
  logic               bot_onehot;
  logic               needs_ld;
  logic               at_limit;
  logic               capture;

  // Bottom-half source select and one-hot check.
  onehot_and_or_mux #(
    .DATA_W (DATA_W),
    .N      (NUM_BOT_SRC)
  ) u_bot_mux (
    .sel      (sel_bot),
    .src      (bot_src),
    .data_c   (bot_sel),
    .onehot_c (bot_onehot)
  );

  // Top-half select and load-dependency / stall request decode.
  always_comb begin
    top_sel   = sel_top ? ld_res_top : ex_data_top;
    needs_ld  = in_valid & (sel_top | sel_bot[LD_IDX]);
    at_limit  = (state == WAIT_LD) && (cnt == CNT_LIMIT);
    stall_req = needs_ld & ~ld_valid & ~at_limit;
    capture   = ~stall & in_valid & ~stall_req;
  end

  // Load-wait controller state, watchdog counter and sticky timeout flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ld_timeout <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      ld_timeout <= timeout_next;
    end
  end

  // Next-state logic; runs independently of stall so the watchdog keeps counting.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    timeout_next = ld_timeout;
    if (flush) begin
      state_next   = IDLE;
      cnt_next     = '0;
      timeout_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (needs_ld && !ld_valid) begin
            state_next = WAIT_LD;
            cnt_next   = CNT_W'(1);
          end
        end
        WAIT_LD: begin
          if (ld_valid) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt < CNT_LIMIT) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
          end else begin
            // Give up on the load: capture what is presented and flag it.
            timeout_next = 1'b1;
            state_next   = IDLE;
            cnt_next     = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // MEM/WB pipeline register: flush beats stall, stall beats capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_data_top <= '0;
      out_data_bot <= '0;
      sel_err      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (stall) begin
      sel_err <= 1'b0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_data_top <= top_sel;
      out_data_bot <= bot_sel;
      sel_err      <= ~bot_onehot;
    end else begin
      // Empty slot or instruction still waiting on its load: emit a bubble.
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end
  end

endmodule

// File: doc/mem_wb_stage_reg.md
Name: mem_wb_stage_reg

Overview:
- Parametrised successor to the MEM/WB data input select. It AND-OR selects the writeback data top and bottom from the EX/MEM, SFR and load sources, then registers them into the MEM/WB pipeline register.
- Adds a valid bit, stall and flush, a wait-for-load handshake with stall request to the hazard unit, a one-hot select checker and a load timeout watchdog.
- Sits between the memory stage and the MEM/WB register file writeback path.

Parameters:
- DATA_W, 8, width of each data half.
- NUM_BOT_SRC, 3, number of bottom-half sources. Order: [0]=SFR, [1]=EX/MEM bot, [2]=load bot, further indices are extra sources.
- LD_IDX, 2, index of the load-result source in bot_src.
- TIMEOUT, 15, maximum WAIT_LD cycles before the watchdog fires. Legal range 1..255.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- sel_top  in  1  0 = ex_data_top, 1 = ld_res_top.
- sel_bot  in  NUM_BOT_SRC  one-hot bottom source select.
- ex_data_top  in  DATA_W  EX/MEM data top.
- ld_res_top  in  DATA_W  load result top.
- bot_src  in  NUM_BOT_SRC*DATA_W  flattened bottom sources; source i is at [i*DATA_W +: DATA_W].
- ld_valid  in  1  load result valid this cycle.
- stall  in  1  downstream hold; MEM/WB register keeps its contents.
- flush  in  1  kill MEM/WB contents.
- out_valid  out  1  MEM/WB valid.
- out_data_top  out  DATA_W  registered top.
- out_data_bot  out  DATA_W  registered bottom.
- stall_req  out  1  combinational; upstream must hold EX/MEM.
- sel_err  out  1  registered one-cycle pulse; sel_bot was not one-hot on a capture.
- ld_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0 except stall_req, which follows state and inputs combinationally.
  - State goes to IDLE and the wait counter is cleared.
- Selection, combinational:
  - top = sel_top ? ld_res_top : ex_data_top.
  - bot = OR over i of (sel_bot[i] ? bot_src[i] : 0).
  - sel_bot all zeros gives bot = 0; multiple bits set give the bitwise OR.
- needs_ld = in_valid & (sel_top | sel_bot[LD_IDX]).
- States:
  - IDLE: if needs_ld & ~ld_valid & ~flush, go to WAIT_LD and set cnt = 1.
  - WAIT_LD: stays while ~ld_valid & cnt < TIMEOUT, with cnt incrementing.
    - On ld_valid, return to IDLE.
    - On cnt == TIMEOUT & ~ld_valid: set ld_timeout (sticky), capture with the load fields as presented, return to IDLE.
- stall_req = needs_ld & ~ld_valid & ~(WAIT_LD & cnt == TIMEOUT).
  - In the ld_valid cycle stall_req is 0, so capture takes 1 cycle.
- Capture condition: ~stall & in_valid & ~stall_req.
  - out_data_top/bot are loaded, out_valid = 1, sel_err = (popcount(sel_bot) != 1).
- in_valid = 0 with ~stall: out_valid = 0, data held, sel_err = 0.
- stall = 1:
  - All MEM/WB registers hold; sel_err drops to 0.
  - The FSM still advances on ld_valid, but ld data is not latched, so upstream must re-present it.
  - The watchdog keeps counting.
- Priority: reset > flush > stall > capture.
  - flush: out_valid = 0, sel_err = 0, state goes to IDLE, cnt = 0. Data regs are don't-care and are held.
  - ld_timeout is cleared only by flush or reset.
- Latency: 1 cycle from inputs to registered outputs when no load wait is needed.
- Counter is 8 bits wide and saturates; it never wraps.

Decomposition:
- Package mem_wb_pkg holds:
  - the state encoding (IDLE = 1'b0, WAIT_LD = 1'b1);
  - localparams SRC_SFR = 0, SRC_EX = 1, SRC_LD = 2;
  - the default DATA_W.
- Sub-module onehot_and_or_mux (parameters DATA_W, N) holds the bottom AND-OR select and a one-hot check output.

Test Plan:
- Reset mid-capture: drive data, pull reset_n low between clock edges -> all outputs 0 immediately; out_valid stays 0 after release until the next valid capture.
- Plain EX path: in_valid = 1, sel_top = 0, sel_bot = 3'b010, ex_data_top = 8'hA5, bot_src[1] = 8'h3C -> next cycle top = A5, bot = 3C, out_valid = 1, stall_req never asserted.
- Load wait: sel_bot = 3'b100, ld_valid low for 3 cycles then high with bot_src[2] = 8'h7E:
  - stall_req high for 3 cycles, then low;
  - out_data_bot = 7E one cycle after ld_valid.
- Timeout: TIMEOUT = 4, ld_valid never asserted -> ld_timeout sets at cnt = 4, capture occurs, flag persists until flush.
- Bad select: sel_bot = 3'b011, bot_src[0] = 8'hF0, bot_src[1] = 8'h0F -> bot = FF, sel_err pulses for 1 cycle.
- Stall vs flush: hold stall with new inputs -> outputs unchanged; assert stall and flush together -> out_valid = 0, state IDLE.
